// File: rtl/seq_detector_param.sv
// seq_detector_param: programmable serial pattern detector with overlap mode and saturating match counter
module seq_detector_param #(
  parameter int PAT_LEN = 3,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               din_valid,
  input  logic               din,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
  output logic               dout,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed
);
  localparam int FW = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam logic [FW-1:0] LAST = FW'(PAT_LEN - 1);
  typedef enum logic [1:0] {EMPTY, FILLING, ARMED} state_t;
  state_t state;
  logic [PAT_LEN-1:0] history, cand;
  logic [FW-1:0] fill, fill_nxt;
  logic hit;
  always_comb begin
    cand = {history[PAT_LEN-2:0], din};
    hit = (state == ARMED) && (cand == pattern);
    fill_nxt = hit ? (overlap ? LAST : '0) : ((fill == LAST) ? LAST : fill + FW'(1));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      history <= '0;
      fill <= '0;
      dout <= 1'b0;
      match_cnt <= '0;
      armed <= 1'b0;
    end else if (clr) begin
      state <= EMPTY;
      history <= '0;
      fill <= '0;
      dout <= 1'b0;
      match_cnt <= '0;
      armed <= 1'b0;
    end else if (din_valid) begin
      history <= cand;
      fill <= fill_nxt;
      state <= (fill_nxt == '0) ? EMPTY : (fill_nxt == LAST) ? ARMED : FILLING;
      armed <= (fill_nxt == LAST);
      dout <= hit;
      // counter sticks at all-ones while the pulse keeps firing
      if (hit && !(&match_cnt)) match_cnt <= match_cnt + CNT_W'(1);
    end else begin
      dout <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: table-driven directed checks plus hand-written async reset sequence
module tb_seq_detector_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic din_valid = 1'b0;
  logic din = 1'b0;
  logic [2:0] pattern = 3'b111;
  logic overlap = 1'b1;
  logic dout, armed, dout2, armed2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_LEN(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
    .pattern(pattern), .overlap(overlap), .dout(dout), .match_cnt(match_cnt), .armed(armed)
  );

  seq_detector_param #(.PAT_LEN(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
    .pattern(pattern), .overlap(overlap), .dout(dout2), .match_cnt(match_cnt2), .armed(armed2)
  );

  typedef struct {
    logic clr, valid, din;
    logic [2:0] pat;
    logic ov;
    logic dout;
    int cnt;
    logic armed;
  } vec_t;
  vec_t v[$];

  task automatic add(input logic c, input logic vl, input logic d, input logic [2:0] p,
                     input logic o, input logic ed, input int ec, input logic ea);
    vec_t t;
    t.clr = c; t.valid = vl; t.din = d; t.pat = p; t.ov = o;
    t.dout = ed; t.cnt = ec; t.armed = ea;
    v.push_back(t);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // T1: 111 overlapping, five ones
    add(1,0,0,3'b111,1, 0,0,0);
    add(0,1,1,3'b111,1, 0,0,0);
    add(0,1,1,3'b111,1, 0,0,1);
    add(0,1,1,3'b111,1, 1,1,1);
    add(0,1,1,3'b111,1, 1,2,1);
    add(0,1,1,3'b111,1, 1,3,1);
    // T2: 111 non-overlapping, six ones
    add(1,0,0,3'b111,0, 0,0,0);
    add(0,1,1,3'b111,0, 0,0,0);
    add(0,1,1,3'b111,0, 0,0,1);
    add(0,1,1,3'b111,0, 1,1,0);
    add(0,1,1,3'b111,0, 0,1,0);
    add(0,1,1,3'b111,0, 0,1,1);
    add(0,1,1,3'b111,0, 1,2,0);
    // T3: 101 overlapping then non-overlapping on 1,0,1,0,1
    add(1,0,0,3'b101,1, 0,0,0);
    add(0,1,1,3'b101,1, 0,0,0);
    add(0,1,0,3'b101,1, 0,0,1);
    add(0,1,1,3'b101,1, 1,1,1);
    add(0,1,0,3'b101,1, 0,1,1);
    add(0,1,1,3'b101,1, 1,2,1);
    add(1,0,0,3'b101,0, 0,0,0);
    add(0,1,1,3'b101,0, 0,0,0);
    add(0,1,0,3'b101,0, 0,0,1);
    add(0,1,1,3'b101,0, 1,1,0);
    add(0,1,0,3'b101,0, 0,1,0);
    add(0,1,1,3'b101,0, 0,1,1);
    // T4: gap of invalid cycles keeps history and armed
    add(1,0,0,3'b111,1, 0,0,0);
    add(0,1,1,3'b111,1, 0,0,0);
    add(0,1,1,3'b111,1, 0,0,1);
    for (int i = 0; i < 4; i++) add(0,0,0,3'b111,1, 0,0,1);
    add(0,1,1,3'b111,1, 1,1,1);
    add(0,0,1,3'b111,1, 0,1,1);
    // T5a: clr on the completing bit discards it
    add(1,0,0,3'b111,1, 0,0,0);
    add(0,1,1,3'b111,1, 0,0,0);
    add(0,1,1,3'b111,1, 0,0,1);
    add(1,1,1,3'b111,1, 0,0,0);
    add(0,1,1,3'b111,1, 0,0,0);
    // T5b: five matches saturate the 2-bit counter
    add(1,0,0,3'b111,1, 0,0,0);
    add(0,1,1,3'b111,1, 0,0,0);
    add(0,1,1,3'b111,1, 0,0,1);
    for (int i = 1; i <= 5; i++) add(0,1,1,3'b111,1, 1,i,1);
    add(0,0,1,3'b111,1, 0,5,1);

    #2;
    chk("reset_dout", int'(dout), 0);
    chk("reset_cnt", int'(match_cnt), 0);
    chk("reset_armed", int'(armed), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (v[i]) begin
      clr = v[i].clr; din_valid = v[i].valid; din = v[i].din;
      pattern = v[i].pat; overlap = v[i].ov;
      step();
      chk($sformatf("v%0d_dout", i), int'(dout), int'(v[i].dout));
      chk($sformatf("v%0d_cnt", i), int'(match_cnt), v[i].cnt);
      chk($sformatf("v%0d_armed", i), int'(armed), int'(v[i].armed));
      chk($sformatf("v%0d_dout2", i), int'(dout2), int'(v[i].dout));
      chk($sformatf("v%0d_cnt2", i), int'(match_cnt2), (v[i].cnt > 3) ? 3 : v[i].cnt);
    end

    // T6: async reset between edges after a match plus two more ones
    clr = 1'b1; din_valid = 1'b0; pattern = 3'b111; overlap = 1'b1;
    step();
    clr = 1'b0; din_valid = 1'b1; din = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t6_pre_cnt", int'(match_cnt), 3);
    chk("t6_pre_dout", int'(dout), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_dout", int'(dout), 0);
    chk("t6_async_cnt", int'(match_cnt), 0);
    chk("t6_async_armed", int'(armed), 0);
    #1 rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("t6_bit%0d_dout", i), int'(dout), (i == 3) ? 1 : 0);
      chk($sformatf("t6_bit%0d_armed", i), int'(armed), (i >= 2) ? 1 : 0);
    end
    chk("t6_cnt", int'(match_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
